bnn_classify_ctrl: RTL
======================

BNN_CLASSIFY_CTRL -- requirements
Module: bnn_classify_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning the number of cycles the image is held stable before scores are captured; legal range 1..255.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port row_valid_i, input, 1 bit: an image row is offered.
REQ-005 SHALL have port row_data_i, input, 8 bits: one binary image row, MSB = leftmost pixel.
REQ-006 SHALL have port row_ready_o, output, 1 bit: a row is accepted on this edge when row_valid_i is also high.
REQ-007 SHALL have port layer_o, output, [0:0][7:0][7:0]: the image driven to the BNN top layer_i.
REQ-008 SHALL have port layer_i, input, [9:0][4:0]: the BNN top layer_o class scores, two's-complement.
REQ-009 SHALL have port res_valid_o, output, 1 bit: a classification result is available.
REQ-010 SHALL have port res_ready_i, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port res_class_o, output, 4 bits: the winning class index, 0..9.
REQ-012 SHALL have port res_score_o, output, 5 bits: the winning signed score.

Function
REQ-013 SHALL implement FSM states LOAD, SETTLE, CAPTURE, SCAN and DONE.
REQ-014 LOAD: row_ready_o=1; row counter k advances 0..7 on each accepted row; row k is written to layer_o[0][7-k].
- The 8th accept SHALL move to SETTLE with k=0.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to CAPTURE.
REQ-016 CAPTURE SHALL, in one cycle, snapshot all 10 layer_i scores into an internal register, then move to SCAN.
REQ-017 SCAN SHALL iterate classes 0..9, one per cycle, over the snapshot.
- The best score SHALL be replaced only when the candidate is strictly greater (signed compare).
- On a tie the lower index SHALL win.
- SCAN SHALL move to DONE after class 9.
REQ-018 res_valid_o SHALL rise exactly SETTLE_CYCLES+11 edges after the edge accepting the 8th row.
REQ-019 DONE: res_valid_o, res_class_o and res_score_o SHALL hold stable until res_valid_o && res_ready_i.
- On that edge the FSM SHALL move to LOAD and res_valid_o SHALL fall.
- res_class_o and res_score_o SHALL keep their values until the next DONE.
REQ-020 row_ready_o SHALL be 0 in every state except LOAD; rows offered outside LOAD SHALL be ignored.
REQ-021 layer_o SHALL keep the previous image until rows of the next image overwrite it, row by row.
REQ-022 A layer_i change after CAPTURE SHALL NOT affect the result.
REQ-023 The score comparison SHALL be performed at 5-bit signed width with no extension overflow: -16 < -1 < 0 < 15.

Reset
REQ-024 While rst_i is high, on each edge the block SHALL set:
- state = LOAD, k = 0, settle count = 0
- layer_o = 0, snapshot = 0
- res_valid_o = 0, res_class_o = 0, res_score_o = 0
REQ-025 row_ready_o SHALL be 0 while rst_i is high and 1 from the first cycle after rst_i falls.
REQ-026 Reset asserted in any state, including mid-LOAD or mid-SCAN, SHALL abandon the operation with no partial result emitted.

Structure
REQ-027 Package bnn_pkg SHALL hold:
- constants NUM_CLASSES=10, SCORE_W=5, IMG_ROWS=8, IMG_COLS=8
- typedefs image_t ([0:0][7:0][7:0]), scores_t ([9:0][4:0]) and the FSM state enum
REQ-028 The argmax datapath SHALL be placed in the single sub-module bnn_argmax_seq (start, snapshot in, class/score/done out); the FSM and row loader SHALL stay in bnn_classify_ctrl.

Verification
REQ-029 Rows 00,00,44,2C,3C,04,04,00 with no gaps -> layer_o == 64'h0000442C3C040400 one cycle after the 8th accept; row_ready_o drops.
REQ-030 Stub scores all -3 except class 6 = +9 -> res_valid_o at SETTLE_CYCLES+11 edges after the 8th accept; res_class_o=6; res_score_o=5'b01001.
REQ-031 Stub scores: class 2 = class 7 = +15, others 0 -> res_class_o=2, res_score_o=5'h0F.
REQ-032 Stub scores all -16 except class 9 = -1 -> res_class_o=9, res_score_o=5'h1F; rows with gapped row_valid_i still produce the same layer_o.
REQ-033 res_ready_i held low 20 cycles in DONE -> outputs stable and row_ready_o=0 throughout; after the handshake, row_ready_o=1 on the next cycle and the next row is accepted.
REQ-034 rst_i pulsed during SCAN (and in a separate run after 3 rows) -> all REQ-024 values hold; a fresh 8-row load then classifies correctly.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN classification controller.
// Holds the image/score geometry, the packed image and score types used
// on the BNN boundary, and the controller FSM state encoding.
package bnn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 5;
  localparam int IMG_ROWS    = 8;
  localparam int IMG_COLS    = 8;

  // One binary image plane: [channel][row][column], row 7 is the top row.
  typedef logic [0:0][IMG_ROWS-1:0][IMG_COLS-1:0] image_t;

  // Per-class two's-complement scores from the BNN output layer.
  typedef logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores_t;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SCAN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bnn_argmax_seq.sv
// Sequential argmax over a frozen score snapshot, one class per cycle.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   start_i      : begin a new scan on the next edge (index restarts at 0)
//   snap_i       : the 10 captured class scores, held stable during the scan
//   class_o      : best class including the candidate examined this cycle
//   score_o      : best score including the candidate examined this cycle
//   done_o       : high in the cycle that examines the last class; class_o and
//                  score_o are then the final result
module bnn_argmax_seq
  import bnn_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  scores_t            snap_i,
  output logic [3:0]         class_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               done_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  logic                      busy_reg;
  logic [3:0]                idx_reg;
  logic [3:0]                best_class_reg;
  logic signed [SCORE_W-1:0] best_score_reg;
  logic signed [SCORE_W-1:0] cand;
  logic                      take;

  // Class 0 seeds the running best; later classes replace it only when
  // strictly greater, so ties keep the lower index. Both operands are
  // declared signed at the native 5-bit width, so -16 compares lowest.
  always_comb begin
    cand    = snap_i[idx_reg];
    take    = (idx_reg == 4'd0) || (cand > best_score_reg);
    class_o = take ? idx_reg : best_class_reg;
    score_o = take ? cand : best_score_reg;
    done_o  = busy_reg && (idx_reg == LAST_IDX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_reg       <= 1'b0;
      idx_reg        <= 4'd0;
      best_class_reg <= 4'd0;
      best_score_reg <= '0;
    end else if (start_i) begin
      busy_reg <= 1'b1;
      idx_reg  <= 4'd0;
    end else if (busy_reg) begin
      best_class_reg <= class_o;
      best_score_reg <= score_o;
      if (done_o) begin
        busy_reg <= 1'b0;
        idx_reg  <= 4'd0;
      end else begin
        idx_reg <= idx_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bnn_classify_ctrl.sv
// Controller that feeds an 8x8 binary image to a BNN and reports the argmax.
// Rows are streamed in with a valid/ready handshake, held on layer_o while
// the network settles, the class scores are snapshotted, scanned for the
// maximum, and the result is offered with a valid/ready handshake.
// Ports:
//   clk_i, rst_i             : clock and synchronous active-high reset
//   row_valid_i, row_data_i  : incoming image row (MSB = leftmost pixel)
//   row_ready_o              : row accepted on an edge where both are high
//   layer_o                  : image driven to the BNN input layer
//   layer_i                  : class scores from the BNN output layer
//   res_valid_o, res_ready_i : result handshake
//   res_class_o, res_score_o : winning class index and its signed score
module bnn_classify_ctrl
  import bnn_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                row_valid_i,
  input  logic [IMG_COLS-1:0] row_data_i,
  output logic                row_ready_o,
  output image_t              layer_o,
  input  scores_t             layer_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [3:0]          res_class_o,
  output logic [SCORE_W-1:0]  res_score_o
);

  localparam logic [2:0] LAST_ROW    = 3'(IMG_ROWS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t               state_reg;
  logic [2:0]           k_reg;
  logic [7:0]           settle_cnt_reg;
  image_t               layer_reg;
  scores_t              snap_reg;
  logic                 res_valid_reg;
  logic [3:0]           res_class_reg;
  logic [SCORE_W-1:0]   res_score_reg;

  logic                 row_accept;
  logic                 scan_start;
  logic [3:0]           scan_class;
  logic [SCORE_W-1:0]   scan_score;
  logic                 scan_done;

  // Gated by rst_i so ready is low during reset yet high in the very first
  // cycle after release (state is already LOAD at that point).
  assign row_ready_o = (state_reg == ST_LOAD) && !rst_i;
  assign row_accept  = row_valid_i && row_ready_o;
  assign scan_start  = (state_reg == ST_CAPTURE);

  assign layer_o     = layer_reg;
  assign res_valid_o = res_valid_reg;
  assign res_class_o = res_class_reg;
  assign res_score_o = res_score_reg;

  bnn_argmax_seq u_argmax (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (scan_start),
    .snap_i  (snap_reg),
    .class_o (scan_class),
    .score_o (scan_score),
    .done_o  (scan_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_LOAD;
      k_reg          <= 3'd0;
      settle_cnt_reg <= 8'd0;
      layer_reg      <= '0;
      snap_reg       <= '0;
      res_valid_reg  <= 1'b0;
      res_class_reg  <= 4'd0;
      res_score_reg  <= '0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (row_accept) begin
            // First row lands in the top row of the plane.
            layer_reg[0][3'd7 - k_reg] <= row_data_i;
            if (k_reg == LAST_ROW) begin
              k_reg     <= 3'd0;
              state_reg <= ST_SETTLE;
            end else begin
              k_reg <= k_reg + 3'd1;
            end
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            settle_cnt_reg <= 8'd0;
            state_reg      <= ST_CAPTURE;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 8'd1;
          end
        end

        ST_CAPTURE: begin
          // Freeze the scores so later layer_i activity cannot reach the scan.
          snap_reg  <= layer_i;
          state_reg <= ST_SCAN;
        end

        ST_SCAN: begin
          // The final step's comparison is folded in combinationally, so the
          // result registers load on the same edge the scan finishes.
          if (scan_done) begin
            res_class_reg <= scan_class;
            res_score_reg <= scan_score;
            res_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (res_ready_i) begin
            res_valid_reg <= 1'b0;
            state_reg     <= ST_LOAD;
          end
        end

        default: state_reg <= ST_LOAD;
      endcase
    end
  end

endmodule
